// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit owning HI/LO: MULT/MULTU/DIV/DIVU hold busy for WIDTH+1 cycles, then pulse done.
// MTHI/MTLO write in one edge with no busy; start is ignored while busy, flush aborts without writing HI/LO.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(1);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(5);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {upper partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mop_q, mop_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic                 is_div_q, is_div_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 signed_op;
  logic                 div_op;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   prod_neg;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    div_op    = (op == OP_DIV) || (op == OP_DIVU);
    abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mop_q};
    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = rem_sh - {1'b0, mop_q};

    prod_neg  = -acc_q;
    quo_fix   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mop_d    = mop_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi_d   = a;
              done_d = 1'b1;
            end else if (op == OP_MTLO) begin
              lo_d   = a;
              done_d = 1'b1;
            end else if (op == OP_MULT || op == OP_MULTU || div_op) begin
              sa_d     = signed_op & a[WIDTH-1];
              sb_d     = signed_op & b[WIDTH-1];
              is_div_d = div_op;
              dz_d     = div_op && (b == '0);
              acc_d    = {{WIDTH{1'b0}}, (div_op ? abs_a : abs_b)};
              mop_d    = div_op ? abs_b : abs_a;
              cnt_d    = '0;
              state_d  = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (is_div_q) begin
            // Negative trial difference means the divisor did not fit: restore.
            if (div_diff[WIDTH]) begin
              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
              acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
          end else if (acc_q[0]) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = dz_q ? {WIDTH{1'b1}} : quo_fix;
          end else if (sa_q ^ sb_q) begin
            hi_d = prod_neg[2*WIDTH-1:WIDTH];
            lo_d = prod_neg[WIDTH-1:0];
          end else begin
            hi_d = acc_q[2*WIDTH-1:WIDTH];
            lo_d = acc_q[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mop_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mop_q    <= mop_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq at WIDTH=32: directed corner cases plus random ops against an arithmetic reference.
module tb_mdu_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_seq #(.WIDTH(32), .OP_W(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int          sx;
    int          sy;
    longint      sp;
    logic [63:0] up;
    logic [31:0] q;
    logic [31:0] r;
    sx = x;
    sy = y;
    ref_calc = '0;
    case (o)
      3'd0: begin
        sp = longint'(sx) * longint'(sy);
        ref_calc = sp;
      end
      3'd1: begin
        up = {32'd0, x} * {32'd0, y};
        ref_calc = up;
      end
      3'd2: begin
        if (y == 32'd0) ref_calc = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ref_calc = {32'd0, x};
        else begin
          q = sx / sy;
          r = sx % sy;
          ref_calc = {r, q};
        end
      end
      3'd3: begin
        if (y == 32'd0) ref_calc = {x, 32'hFFFF_FFFF};
        else ref_calc = {x % y, x / y};
      end
      default: ref_calc = {exp_hi, exp_lo};
    endcase
  endfunction

  // Issue an iterative op and check busy length, done pulse and result.
  // poke>0 drives a competing start on that busy cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int poke, input string tag);
    logic [63:0] r;
    int nb;
    r = ref_calc(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      if (nb == poke) begin
        start = 1'b1; op = 3'd2; a = $urandom; b = $urandom | 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    chk({tag, ".busy_cycles"}, 64'(nb), 64'd33);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    chk({tag, ".done_end"}, 64'(done), 64'd0);
  endtask

  initial begin
    int seen_done;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    resetn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    exp_hi = '0; exp_lo = '0;
    #1;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    do_op(3'd0, 32'hFFFF_FFFD, 32'd7,        0, "mult_neg");
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2,        0, "div_neg");
    do_op(3'd3, 32'd100,       32'd7,        0, "divu");
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(3'd3, 32'h0000_1234, 32'd0,        0, "divu_by0");
    do_op(3'd2, 32'hFFFF_FF00, 32'd0,        0, "div_by0");
    do_op(3'd0, 32'h8000_0000, 32'h8000_0000, 0, "mult_min");
    do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5, "busy_start");

    // MTHI / MTLO
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hA5A5_A5A5;
    @(negedge clk);
    start = 1'b0;
    exp_hi = 32'hA5A5_A5A5;
    chk("mthi.hi", 64'(hi), 64'(exp_hi));
    chk("mthi.lo", 64'(lo), 64'(exp_lo));
    chk("mthi.busy", 64'(busy), 64'd0);
    chk("mthi.done", 64'(done), 64'd1);
    @(negedge clk);
    chk("mthi.done_end", 64'(done), 64'd0);
    start = 1'b1; op = 3'd5; a = 32'h0F0F_3C3C;
    @(negedge clk);
    start = 1'b0;
    exp_lo = 32'h0F0F_3C3C;
    chk("mtlo.lo", 64'(lo), 64'(exp_lo));
    chk("mtlo.done", 64'(done), 64'd1);

    // Reserved op does nothing
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("rsvd.busy", 64'(busy), 64'd0);
    chk("rsvd.done", 64'(done), 64'd0);
    chk("rsvd.hilo", {hi, lo}, {exp_hi, exp_lo});

    // Flush on busy cycle 10 of a MULT
    start = 1'b1; op = 3'd0; a = 32'd12345; b = 32'hFFFF_0001;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    chk("flush.busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.busy", 64'(busy), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    chk("flush.no_done", 64'(seen_done), 64'd0);
    chk("flush.hilo", {hi, lo}, {exp_hi, exp_lo});

    // Asynchronous reset mid-DIV
    start = 1'b1; op = 3'd2; a = 32'hF000_0001; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    do_op(3'd3, 32'hFFFF_FFF0, 32'd13, 0, "post_rst_divu");

    // Random operations
    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      do_op(ro, ra, rb, 0, $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair.
- Executes the MULT, MULTU, DIV, DIVU, MTHI and MTLO operations produced by ALU decode; MFHI/MFLO read the hi/lo outputs directly.
- Sits beside the ALU in EX and raises busy so the pipeline stalls while an iterative operation runs.
- Generalises the earlier single-cycle HI/LO handling to WIDTH bits, adding signed/unsigned iterative datapaths, a busy/done handshake and flush.

Parameters:
- WIDTH, 32, operand and HI/LO register width; must be >= 4.
- OP_W, 3, width of the op port.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  OP_W  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 reserved (no operation).
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI, MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  abort any operation in flight.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse; HI/LO updated on this cycle's preceding edge.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, all internal registers cleared. Assertion mid-operation discards the operation.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 with op in {MTHI, MTLO}: at the edge, hi (or lo) <= a; done pulses the next cycle; busy stays 0; state stays IDLE.
  - start=1 with op in {MULT, MULTU, DIV, DIVU}: at edge E0, capture operand magnitudes (two's-complement absolute value for signed ops), sign flags and op; clear the iteration counter; go to CALC; busy=1 from E0.
  - Reserved op: ignored entirely.
- CALC: one iteration per cycle, exactly WIDTH iterations (edges E1..E_WIDTH), then go to FIX.
  - Multiply: radix-2 shift-add. Each iteration conditionally adds the multiplicand to the upper half of the 2*WIDTH partial product, then shifts right one bit.
  - Divide: restoring shift-subtract on the magnitudes, producing one quotient bit per cycle.
- FIX (edge E_WIDTH+1):
  - Apply signs. Product is negated when sa^sb. Quotient is negated when sa^sb. Remainder takes the sign of the dividend (sa).
  - Write hi <= upper/remainder and lo <= lower/quotient.
  - Return to IDLE. busy=0 and done=1 for exactly one cycle after this edge.
  - Total: busy high for WIDTH+1 cycles; done high in the cycle following E_WIDTH+1.
- Divide by zero (b=0), both DIV and DIVU: result is hi=a and lo=all ones. Timing is unchanged (full WIDTH+1 cycles).
- DIV of the most-negative value by -1: lo=most-negative value, hi=0. No trap.
- start while busy=1: ignored; the operation in flight is unaffected.
- flush=1: at the next edge, state=IDLE and busy=0. hi/lo are NOT written and done is not pulsed. flush has priority over start and over a FIX write in the same cycle.
- hi/lo change only on an MTHI/MTLO write, a FIX write, or reset.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles; done one cycle; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=7 -> lo=14, hi=2.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234 b=0 -> hi=0x1234, lo=0xFFFFFFFF after 33 busy cycles.
- MTHI a=0xA5A5A5A5 -> hi updated next edge, busy stays 0, done pulses.
- A second start issued while busy -> ignored.
- flush at cycle 10 of a MULT -> busy drops next cycle, hi/lo hold their prior values, no done.
- resetn low mid-DIV -> busy=0, hi=lo=0 immediately; a fresh DIVU afterwards completes correctly.
